// File: rtl/fir_out_decim_fifo.sv
// Decimating output stage for the FIR: keeps every DECIM-th valid sample,
// rounds/saturates it to the output width and buffers it in a small FIFO
// drained through a valid/ready interface.
module fir_out_decim_fifo #(
  parameter int unsigned WIDTH_data = 24,
  parameter int unsigned WIDTH_out  = 16,
  parameter int unsigned DECIM      = 4,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [WIDTH_data-1:0]    data_in,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [WIDTH_out-1:0]     data_out,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     overflow,
  input  logic                     clr_ovf
);

  localparam int unsigned Drop  = WIDTH_data - WIDTH_out;
  localparam int unsigned PhW   = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned ExtW  = WIDTH_data + 1;

  localparam logic signed [ExtW-1:0] Half   = ExtW'(1) << (Drop - 1);
  localparam logic signed [ExtW-1:0] MaxPos = (ExtW'(1) << (WIDTH_out - 1)) - ExtW'(1);
  localparam logic signed [ExtW-1:0] MinNeg = ExtW'(0) - (ExtW'(1) << (WIDTH_out - 1));
  localparam logic [WIDTH_out-1:0]   SatPos = {1'b0, {(WIDTH_out - 1){1'b1}}};
  localparam logic [WIDTH_out-1:0]   SatNeg = {1'b1, {(WIDTH_out - 1){1'b0}}};
  localparam logic [AddrW:0]         FullLvl = (AddrW + 1)'(DEPTH);

  logic [PhW-1:0]        phase_q, phase_d;
  logic                  keep;
  logic signed [ExtW-1:0] ext, sum, shr;
  logic [WIDTH_out-1:0]  sat;
  logic                  s1_valid_q;
  logic [WIDTH_out-1:0]  s1_data_q;
  logic [WIDTH_out-1:0]  mem_q [DEPTH];
  logic [AddrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]        fill_q, fill_d;
  logic                  ovf_q, ovf_d;
  logic                  full, pop, push, drop;

  // Decimation phase: advances on valid input only, a sample is kept at phase 0
  always_comb begin
    phase_d = phase_q;
    if (in_valid) begin
      phase_d = (phase_q == PhW'(DECIM - 1)) ? '0 : phase_q + PhW'(1);
    end
    keep = in_valid && (phase_q == '0);
  end

  // Round half up, then clamp to the signed output range
  always_comb begin
    ext = signed'({data_in[WIDTH_data-1], data_in});
    sum = ext + Half;
    shr = sum >>> Drop;
    if (shr > MaxPos) begin
      sat = SatPos;
    end else if (shr < MinNeg) begin
      sat = SatNeg;
    end else begin
      sat = shr[WIDTH_out-1:0];
    end
  end

  // FIFO control; a full FIFO still accepts a write when a pop frees a slot
  always_comb begin
    full   = (fill_q == FullLvl);
    pop    = out_valid && out_ready;
    push   = s1_valid_q && (!full || pop);
    drop   = s1_valid_q && full && !pop;
    fill_d = fill_q;
    if (push && !pop) begin
      fill_d = fill_q + (AddrW + 1)'(1);
    end else if (pop && !push) begin
      fill_d = fill_q - (AddrW + 1)'(1);
    end
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  // Phase counter, stage-1 register, pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q    <= '0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      s1_valid_q <= keep;
      if (keep) begin
        s1_data_q <= sat;
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AddrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AddrW'(1);
      end
      fill_q <= fill_d;
      ovf_q  <= ovf_d;
    end
  end

  // Storage array; contents are only observed through the occupancy gate
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= s1_data_q;
    end
  end

  // Head of FIFO, forced to zero while empty so nothing undefined leaks out
  always_comb begin
    out_valid  = (fill_q != '0);
    data_out   = out_valid ? mem_q[rd_ptr_q] : '0;
    fill_level = fill_q;
    overflow   = ovf_q;
  end

endmodule

// File: tb/tb_fir_out_decim_fifo.sv
// Bench for fir_out_decim_fifo: three instances (DECIM = 1, 2, 4), one driven
// at a time, checked against a queue-based reference model.
module tb_fir_out_decim_fifo;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid   [3];
  logic [23:0] data_in    [3];
  logic        out_ready  [3];
  logic        out_valid  [3];
  logic [15:0] data_out   [3];
  logic [3:0]  fill_level [3];
  logic        overflow   [3];
  logic        clr_ovf    [3];

  int decim_of [3] = '{1, 2, 4};
  int k;
  int errors = 0;
  int checks = 0;

  // Reference model: FIFO contents as a queue, one sample in flight
  logic [15:0] mq [$];
  logic [15:0] mpend;
  bit          mpend_v;
  int          mvalid;
  bit          movf;

  always #5 clk = ~clk;

  fir_out_decim_fifo #(.WIDTH_data(24), .WIDTH_out(16), .DECIM(1), .DEPTH(DEPTH)) u_d1 (
    .clk(clk), .reset(reset), .in_valid(in_valid[0]), .data_in(data_in[0]),
    .out_ready(out_ready[0]), .out_valid(out_valid[0]), .data_out(data_out[0]),
    .fill_level(fill_level[0]), .overflow(overflow[0]), .clr_ovf(clr_ovf[0])
  );
  fir_out_decim_fifo #(.WIDTH_data(24), .WIDTH_out(16), .DECIM(2), .DEPTH(DEPTH)) u_d2 (
    .clk(clk), .reset(reset), .in_valid(in_valid[1]), .data_in(data_in[1]),
    .out_ready(out_ready[1]), .out_valid(out_valid[1]), .data_out(data_out[1]),
    .fill_level(fill_level[1]), .overflow(overflow[1]), .clr_ovf(clr_ovf[1])
  );
  fir_out_decim_fifo #(.WIDTH_data(24), .WIDTH_out(16), .DECIM(4), .DEPTH(DEPTH)) u_d4 (
    .clk(clk), .reset(reset), .in_valid(in_valid[2]), .data_in(data_in[2]),
    .out_ready(out_ready[2]), .out_valid(out_valid[2]), .data_out(data_out[2]),
    .fill_level(fill_level[2]), .overflow(overflow[2]), .clr_ovf(clr_ovf[2])
  );

  // Round half up to 16 bits with plain integer arithmetic, then clamp
  function automatic logic [15:0] round_sat(input logic [23:0] x);
    int v;
    int r;
    v = int'($signed(x)) + 128;
    r = (v >= 0) ? v / 256 : -((-v + 255) / 256);
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r[15:0];
  endfunction

  // Drive one cycle on instance k, advance the model, return 1 ns after the edge
  task automatic tick(input bit rst, input bit iv, input logic [23:0] d,
                      input bit rdy, input bit clr);
    bit pop;
    bit drop;
    for (int j = 0; j < 3; j++) begin
      in_valid[j] = 1'b0; data_in[j] = '0; out_ready[j] = 1'b0; clr_ovf[j] = 1'b0;
    end
    reset = rst; in_valid[k] = iv; data_in[k] = d; out_ready[k] = rdy; clr_ovf[k] = clr;
    if (rst) begin
      mq.delete(); mpend_v = 0; mvalid = 0; movf = 0;
    end else begin
      pop  = (mq.size() > 0) && rdy;
      drop = 0;
      if (pop) void'(mq.pop_front());
      if (mpend_v) begin
        if (mq.size() < DEPTH) mq.push_back(mpend);
        else drop = 1;
      end
      if (drop) movf = 1;
      else if (clr) movf = 0;
      mpend_v = iv && (mvalid % decim_of[k] == 0);
      mpend   = round_sat(d);
      if (iv) mvalid++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    k = 2;
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    checks++; if (out_valid[k] !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b want 0", out_valid[k]); end
    checks++; if (data_out[k] !== 16'h0) begin
      errors++; $display("FAIL reset_data: got %h want 0000", data_out[k]); end
    checks++; if (fill_level[k] !== 4'd0) begin
      errors++; $display("FAIL reset_fill: got %0d want 0", fill_level[k]); end
    checks++; if (overflow[k] !== 1'b0) begin
      errors++; $display("FAIL reset_ovf: got %b want 0", overflow[k]); end
  endtask

  task automatic test_decim4();
    logic [23:0] din [5] = '{24'h000180, 24'h000100, 24'h000200, 24'h000300, 24'h00017F};
    logic [15:0] got [$];
    k = 2;
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      tick(0, i < 5, (i < 5) ? din[i % 5] : 24'h0, 1, 0);
      if (out_valid[k] === 1'b1) got.push_back(data_out[k]);
      if (i == 0) begin
        checks++; if (out_valid[k] !== 1'b0) begin
          errors++; $display("FAIL d4_latency1: got %b want 0", out_valid[k]); end
      end
      if (i == 1) begin
        checks++; if (out_valid[k] !== 1'b1) begin
          errors++; $display("FAIL d4_latency2: got %b want 1", out_valid[k]); end
      end
      checks++; if (fill_level[k] !== 4'(mq.size())) begin
        errors++; $display("FAIL d4_fill: got %0d want %0d", fill_level[k], mq.size()); end
    end
    checks++; if (got.size() != 2) begin
      errors++; $display("FAIL d4_count: got %0d want 2", got.size()); end
    else begin
      checks++; if (got[0] !== 16'h0002) begin
        errors++; $display("FAIL d4_out0: got %h want 0002", got[0]); end
      checks++; if (got[1] !== 16'h0001) begin
        errors++; $display("FAIL d4_out1: got %h want 0001", got[1]); end
    end
  endtask

  task automatic test_round_sat();
    logic [23:0] din [4] = '{24'h7FFFFF, 24'h800000, 24'hFFFE80, 24'hFFFE7F};
    logic [15:0] want [4] = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'hFFFE};
    logic [15:0] got [$];
    k = 0;
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      tick(0, i < 4, (i < 4) ? din[i % 4] : 24'h0, 1, 0);
      if (out_valid[k] === 1'b1) got.push_back(data_out[k]);
    end
    checks++; if (got.size() != 4) begin
      errors++; $display("FAIL rs_count: got %0d want 4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      checks++; if (got[i] !== want[i]) begin
        errors++; $display("FAIL rs_out%0d: got %h want %h", i, got[i], want[i]); end
    end
  endtask

  task automatic test_overflow();
    logic [23:0] sent [10];
    k = 0;
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      sent[i] = 24'($urandom);
      tick(0, 1, sent[i], 0, 0);
      checks++; if (fill_level[k] !== 4'(mq.size())) begin
        errors++; $display("FAIL ovf_fill%0d: got %0d want %0d", i, fill_level[k], mq.size());
      end
      if (i == 8 || i == 9) begin
        checks++; if (overflow[k] !== (i == 9)) begin
          errors++; $display("FAIL ovf_flag%0d: got %b want %b", i, overflow[k], i == 9); end
      end
    end
    tick(0, 0, 0, 0, 0);
    checks++; if (fill_level[k] !== 4'd8 || overflow[k] !== 1'b1) begin
      errors++; $display("FAIL ovf_full: got fill=%0d ovf=%b want 8/1", fill_level[k],
                         overflow[k]); end
    tick(0, 0, 0, 0, 1);
    checks++; if (overflow[k] !== 1'b0) begin
      errors++; $display("FAIL ovf_clear: got %b want 0", overflow[k]); end
    tick(0, 1, 24'h123456, 0, 0);
    tick(0, 0, 0, 0, 1);
    checks++; if (overflow[k] !== 1'b1) begin
      errors++; $display("FAIL ovf_clr_vs_drop: got %b want 1", overflow[k]); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (out_valid[k] !== 1'b1 || data_out[k] !== round_sat(sent[i])) begin
        errors++; $display("FAIL ovf_drain%0d: got v=%b d=%h want 1/%h", i, out_valid[k],
                           data_out[k], round_sat(sent[i])); end
      tick(0, 0, 0, 1, 0);
    end
    checks++; if (fill_level[k] !== 4'd0 || out_valid[k] !== 1'b0) begin
      errors++; $display("FAIL ovf_empty: got fill=%0d v=%b want 0/0", fill_level[k],
                         out_valid[k]); end
  endtask

  task automatic test_full_pop_push();
    logic [23:0] sent [8];
    logic [23:0] dnew;
    k = 0;
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      sent[i] = 24'($urandom);
      tick(0, 1, sent[i], 0, 0);
    end
    tick(0, 0, 0, 0, 0);
    dnew = 24'($urandom);
    tick(0, 1, dnew, 0, 0);
    tick(0, 0, 0, 1, 0);
    checks++; if (fill_level[k] !== 4'd8 || overflow[k] !== 1'b0) begin
      errors++; $display("FAIL fpp_state: got fill=%0d ovf=%b want 8/0", fill_level[k],
                         overflow[k]); end
    for (int i = 1; i < 9; i++) begin
      checks++;
      if (data_out[k] !== round_sat((i < 8) ? sent[i % 8] : dnew) || out_valid[k] !== 1'b1)
      begin
        errors++; $display("FAIL fpp_drain%0d: got v=%b d=%h want 1/%h", i, out_valid[k],
                           data_out[k], round_sat((i < 8) ? sent[i % 8] : dnew)); end
      tick(0, 0, 0, 1, 0);
    end
  endtask

  task automatic test_phase_hold();
    bit          pat  [7] = '{1, 0, 0, 1, 1, 0, 1};
    logic [15:0] got [$];
    k = 1;
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      tick(0, (i < 7) ? pat[i % 7] : 1'b0, 24'((i + 1) * 256), 1, 0);
      if (out_valid[k] === 1'b1) got.push_back(data_out[k]);
    end
    checks++; if (got.size() != 2) begin
      errors++; $display("FAIL ph_count: got %0d want 2", got.size()); end
    else begin
      checks++; if (got[0] !== 16'd1 || got[1] !== 16'd5) begin
        errors++; $display("FAIL ph_values: got %h,%h want 0001,0005", got[0], got[1]); end
    end
  endtask

  task automatic test_reset_mid();
    k = 2;
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < 21; i++) tick(0, 1, 24'(i * 256), 0, 0);
    checks++; if (fill_level[k] !== 4'd5) begin
      errors++; $display("FAIL rm_pre: got %0d want 5", fill_level[k]); end
    tick(1, 0, 0, 0, 0);
    checks++;
    if (fill_level[k] !== 4'd0 || out_valid[k] !== 1'b0 || overflow[k] !== 1'b0) begin
      errors++; $display("FAIL rm_post: got fill=%0d v=%b ovf=%b want 0/0/0", fill_level[k],
                         out_valid[k], overflow[k]); end
    tick(0, 1, 24'h00AB00, 0, 0);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    checks++;
    if (out_valid[k] !== 1'b1 || data_out[k] !== 16'h00AB || fill_level[k] !== 4'd1) begin
      errors++; $display("FAIL rm_next: got v=%b d=%h fill=%0d want 1/00ab/1", out_valid[k],
                         data_out[k], fill_level[k]); end
  endtask

  task automatic test_random();
    for (int kk = 0; kk < 3; kk++) begin
      k = kk;
      tick(1, 0, 0, 0, 0);
      for (int c = 0; c < 400; c++) begin
        tick(0, $urandom_range(0, 3) != 0, 24'($urandom),
             $urandom_range(0, 2 * kk + 2) == 0, $urandom_range(0, 15) == 0);
        checks++; if (out_valid[k] !== (mq.size() > 0)) begin
          errors++; $display("FAIL rnd_valid k%0d c%0d: got %b want %b", k, c, out_valid[k],
                             mq.size() > 0); end
        checks++; if (fill_level[k] !== 4'(mq.size())) begin
          errors++; $display("FAIL rnd_fill k%0d c%0d: got %0d want %0d", k, c, fill_level[k],
                             mq.size()); end
        checks++; if (overflow[k] !== movf) begin
          errors++; $display("FAIL rnd_ovf k%0d c%0d: got %b want %b", k, c, overflow[k],
                             movf); end
        if (mq.size() > 0) begin
          checks++; if (data_out[k] !== mq[0]) begin
            errors++; $display("FAIL rnd_data k%0d c%0d: got %h want %h", k, c, data_out[k],
                               mq[0]); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_decim4();
    test_round_sat();
    test_overflow();
    test_full_pop_push();
    test_phase_hold();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
